// File: rtl/bellek_denetleyici.sv
// Memory-stage sequencer: drives load/store uops onto the L1D valid/ready port,
// splits accesses that cross a word boundary and aligns/extends load data.
module bellek_denetleyici #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 istek_gecerli_i,
    input  logic                 istek_yaz_i,
    input  logic [ADRES_BIT-1:0] istek_adres_i,
    input  logic [1:0]           istek_boyut_i,
    input  logic                 istek_isaretli_i,
    input  logic [VERI_BIT-1:0]  istek_veri_i,
    output logic                 duraklat_o,
    output logic                 sonuc_gecerli_o,
    output logic [VERI_BIT-1:0]  sonuc_veri_o,
    output logic                 l1v_istek_gecerli_o,
    input  logic                 l1v_istek_hazir_i,
    output logic [ADRES_BIT-1:0] l1v_istek_adres_o,
    output logic                 l1v_istek_yaz_o,
    output logic [VERI_BIT-1:0]  l1v_istek_veri_o,
    output logic [3:0]           l1v_istek_maske_o,
    input  logic [VERI_BIT-1:0]  l1v_veri_i,
    input  logic                 l1v_veri_gecerli_i,
    output logic                 l1v_veri_hazir_o
);

    typedef enum logic [2:0] {BOSTA, ISTEK1, BEKLE1, ISTEK2, BEKLE2, TAMAM} durum_t;

    durum_t                 durum_q;
    logic                   yaz_q, isaretli_q;
    logic [1:0]             boyut_q;
    logic [ADRES_BIT-1:0]   adres_q;
    logic [VERI_BIT-1:0]    veri_q, rd1_q, rd2_q;

    logic                   istekGecerli_q, istekYaz_q, veriHazir_q, sonucGecerli_q;
    logic [ADRES_BIT-1:0]   istekAdres_q;
    logic [VERI_BIT-1:0]    istekVeri_q;
    logic [3:0]             istekMaske_q;

    logic [ADRES_BIT-1:0]   kayAdres;
    logic [VERI_BIT-1:0]    kayVeri;
    logic [1:0]             kayBoyut, ofs;
    logic [2:0]             nBayt;
    logic                   bolunmus;
    logic [2*VERI_BIT-1:0]  seritVeri, kaymis;
    logic [7:0]             seritMaske;
    logic [VERI_BIT-1:0]    sonucHam;

    // In BOSTA the first request is built straight from the inputs being latched.
    always_comb begin
        kayAdres = (durum_q == BOSTA) ? istek_adres_i : adres_q;
        kayVeri  = (durum_q == BOSTA) ? istek_veri_i  : veri_q;
        kayBoyut = (durum_q == BOSTA) ? istek_boyut_i : boyut_q;
        ofs      = kayAdres[1:0];
        case (kayBoyut)
            2'b00:   nBayt = 3'd1;
            2'b01:   nBayt = 3'd2;
            default: nBayt = 3'd4;
        endcase
        bolunmus   = ({1'b0, ofs} + nBayt) > 3'd4;
        seritVeri  = {{VERI_BIT{1'b0}}, kayVeri} << {ofs, 3'b000};
        seritMaske = ((8'd1 << nBayt) - 8'd1) << ofs;
        kaymis     = {rd2_q, rd1_q} >> {ofs, 3'b000};
        case (boyut_q)
            2'b00:   sonucHam = {{(VERI_BIT-8){isaretli_q & kaymis[7]}}, kaymis[7:0]};
            2'b01:   sonucHam = {{(VERI_BIT-16){isaretli_q & kaymis[15]}}, kaymis[15:0]};
            default: sonucHam = kaymis[VERI_BIT-1:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            durum_q        <= BOSTA;
            yaz_q          <= 1'b0;
            isaretli_q     <= 1'b0;
            boyut_q        <= 2'b00;
            adres_q        <= '0;
            veri_q         <= '0;
            rd1_q          <= '0;
            rd2_q          <= '0;
            istekGecerli_q <= 1'b0;
            istekYaz_q     <= 1'b0;
            istekAdres_q   <= '0;
            istekVeri_q    <= '0;
            istekMaske_q   <= 4'b0000;
            veriHazir_q    <= 1'b0;
            sonucGecerli_q <= 1'b0;
        end else begin
            case (durum_q)
                BOSTA: begin
                    if (istek_gecerli_i) begin
                        yaz_q          <= istek_yaz_i;
                        isaretli_q     <= istek_isaretli_i;
                        boyut_q        <= istek_boyut_i;
                        adres_q        <= istek_adres_i;
                        veri_q         <= istek_veri_i;
                        rd1_q          <= '0;
                        rd2_q          <= '0;
                        istekGecerli_q <= 1'b1;
                        istekYaz_q     <= istek_yaz_i;
                        istekAdres_q   <= {kayAdres[ADRES_BIT-1:2], 2'b00};
                        istekVeri_q    <= istek_yaz_i ? seritVeri[VERI_BIT-1:0] : '0;
                        istekMaske_q   <= istek_yaz_i ? seritMaske[3:0] : 4'b0000;
                        durum_q        <= ISTEK1;
                    end
                end
                ISTEK1, ISTEK2: begin
                    if (l1v_istek_hazir_i) begin
                        istekGecerli_q <= 1'b0;
                        istekYaz_q     <= 1'b0;
                        istekAdres_q   <= '0;
                        istekVeri_q    <= '0;
                        istekMaske_q   <= 4'b0000;
                        veriHazir_q    <= 1'b1;
                        durum_q        <= (durum_q == ISTEK1) ? BEKLE1 : BEKLE2;
                    end
                end
                BEKLE1: begin
                    if (l1v_veri_gecerli_i && veriHazir_q) begin
                        rd1_q       <= l1v_veri_i;
                        veriHazir_q <= 1'b0;
                        if (bolunmus) begin
                            // Second beat targets the next word; wraps at the top of the space.
                            istekGecerli_q <= 1'b1;
                            istekYaz_q     <= yaz_q;
                            istekAdres_q   <= {adres_q[ADRES_BIT-1:2], 2'b00} + ADRES_BIT'(4);
                            istekVeri_q    <= yaz_q ? seritVeri[2*VERI_BIT-1:VERI_BIT] : '0;
                            istekMaske_q   <= yaz_q ? seritMaske[7:4] : 4'b0000;
                            durum_q        <= ISTEK2;
                        end else begin
                            sonucGecerli_q <= 1'b1;
                            durum_q        <= TAMAM;
                        end
                    end
                end
                BEKLE2: begin
                    if (l1v_veri_gecerli_i && veriHazir_q) begin
                        rd2_q          <= l1v_veri_i;
                        veriHazir_q    <= 1'b0;
                        sonucGecerli_q <= 1'b1;
                        durum_q        <= TAMAM;
                    end
                end
                TAMAM: begin
                    sonucGecerli_q <= 1'b0;
                    durum_q        <= BOSTA;
                end
                default: durum_q <= BOSTA;
            endcase
        end
    end

    assign duraklat_o          = istek_gecerli_i && (durum_q != TAMAM);
    assign sonuc_gecerli_o     = sonucGecerli_q;
    assign sonuc_veri_o        = (sonucGecerli_q && !yaz_q) ? sonucHam : '0;
    assign l1v_istek_gecerli_o = istekGecerli_q;
    assign l1v_istek_adres_o   = istekAdres_q;
    assign l1v_istek_yaz_o     = istekYaz_q;
    assign l1v_istek_veri_o    = istekVeri_q;
    assign l1v_istek_maske_o   = istekMaske_q;
    assign l1v_veri_hazir_o    = veriHazir_q;

endmodule
